sync_fifo_param: RTL and testbench

//  Parametrised synchronous single-clock FIFO, next generation of the team's 8x8 sync FIFO.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_fifo_mem.sv | 22 ++
 rtl/sync_fifo_param.sv | 113 +++++++++++
 tb/tb_sync_fifo_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, types and helpers for the sync FIFO family
package fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_AFULL_TH  = 6;
    localparam int DEF_AEMPTY_TH = 2;

    // Encoded as {wr_acc, rd_acc} so the level update can switch on it directly.
    typedef enum logic [1:0] {
        LVL_HOLD = 2'b00,
        LVL_POP  = 2'b01,
        LVL_PUSH = 2'b10,
        LVL_SWAP = 2'b11
    } lvl_op_e;

    function automatic int fifo_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with std/FWFT read and sticky errors
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   AFULL_L  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AEMPTY_L = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              rd_acc;
    logic              wr_acc;
    lvl_op_e           lvl_op;
    logic [DATA_W-1:0] mem_rd_data;

    assign empty        = (level_q == '0);
    assign full         = (level_q == DEPTH_L);
    assign almost_full  = (level_q >= AFULL_L);
    assign almost_empty = (level_q <= AEMPTY_L);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop in the same cycle frees the slot, so a write into a full FIFO is still taken.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);
    assign lvl_op = lvl_op_e'({wr_acc, rd_acc});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            case (lvl_op)
                LVL_PUSH: level_q <= level_q + LVL_ONE;
                LVL_POP:  level_q <= level_q - LVL_ONE;
                default:  level_q <= level_q;
            endcase
            overflow_q  <= (wr_en & ~wr_acc) | (overflow_q & ~clr_err);
            underflow_q <= (rd_en & empty) | (underflow_q & ~clr_err);
        end
    end

    // Async read of the head slot; when full with a same-cycle write, the old word is read.
    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = empty ? '0 : mem_rd_data;
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_rd_data;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param, std and FWFT instances
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] level;

    logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
    logic [7:0] f_wr_data = 8'h00;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_level;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_d;
    int         m_level = 0;
    bit         m_ovf = 0, m_udf = 0, exp_rd = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .level(f_level),
        .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
    );

    // One clock of stimulus on the std instance; the model decides acceptance before the edge.
    task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        bit ra, wa, ud;
        ra = re && (m_level > 0);
        wa = we && ((m_level < 8) || ra);
        ud = re && (m_level == 0);
        wr_en = we; wr_data = wd; rd_en = re; clr_err = clr;
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; clr_err = 0;
        if (wa) sb.push_back(wd);
        m_level = m_level + int'(wa) - int'(ra);
        m_ovf = (we && !wa) || (m_ovf && !clr);
        m_udf = ud || (m_udf && !clr);
        exp_rd = ra;
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0; m_ovf = 0; m_udf = 0; exp_rd = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
        @(posedge clk); #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b exp 1", empty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty got %0b exp 1", almost_empty); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %0h exp 0", rd_data); end
        checks++; if ({full, almost_full, overflow, underflow, rd_valid} !== 5'b0) begin
            errors++; $display("FAIL rst_flags got %05b exp 00000", {full, almost_full, overflow, underflow, rd_valid});
        end
        checks++; if ({f_empty, f_rd_valid, f_rd_data} !== {1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL rst_fwft got e=%0b v=%0b d=%0h exp e=1 v=0 d=0", f_empty, f_rd_valid, f_rd_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            step(1, 8'(i), 0, 0);
            checks++; if (level !== 4'(m_level)) begin errors++; $display("FAIL fill_level got %0d exp %0d", level, m_level); end
            checks++; if (almost_full !== (m_level >= 6)) begin errors++; $display("FAIL fill_afull got %0b at level %0d", almost_full, m_level); end
            checks++; if (almost_empty !== (m_level <= 2)) begin errors++; $display("FAIL fill_aempty got %0b at level %0d", almost_empty, m_level); end
            checks++; if (full !== (m_level == 8)) begin errors++; $display("FAIL fill_full got %0b at level %0d", full, m_level); end
        end
        step(1, 8'hFF, 0, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", level); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            step(0, 8'h00, 1, 0);
            checks++; if (rd_valid !== exp_rd) begin errors++; $display("FAIL drain_valid got %0b exp %0b", rd_valid, exp_rd); end
            if (rd_valid === 1'b1 && sb.size() > 0) begin
                exp_d = sb.pop_front();
                checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL drain_data got %0h exp %0h", rd_data, exp_d); end
            end
            checks++; if (level !== 4'(m_level)) begin errors++; $display("FAIL drain_level got %0d exp %0d", level, m_level); end
        end
        step(0, 8'h00, 1, 0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set got %0b exp 1", underflow); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL udf_valid got %0b exp 0", rd_valid); end
        checks++; if (rd_data !== 8'h08) begin errors++; $display("FAIL udf_hold got %0h exp 08", rd_data); end
        checks++; if (empty !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL udf_empty got e=%0b l=%0d exp e=1 l=0", empty, level); end
    endtask

    task automatic test_clr_err();
        step(0, 8'h00, 1, 1);
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL clr_ovf got %0b exp %0b", overflow, m_ovf); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clr_set_wins got %0b exp 1", underflow); end
        step(0, 8'h00, 0, 1);
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_both got %02b exp 00", {overflow, underflow}); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0);
        step(1, 8'hAA, 1, 0);
        checks++; if (level !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL frw_level got %0d full=%0b exp 8 full=1", level, full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf got %0b exp 0", overflow); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (rd_valid !== exp_rd) begin errors++; $display("FAIL frw_valid got %0b exp %0b", rd_valid, exp_rd); end
            if (rd_valid === 1'b1 && sb.size() > 0) begin
                exp_d = sb.pop_front();
                checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL frw_data got %0h exp %0h", rd_data, exp_d); end
            end
            if (i < 8) step(0, 8'h00, 1, 0);
        end
        checks++; if (rd_data !== 8'hAA) begin errors++; $display("FAIL frw_last got %0h exp aa", rd_data); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 24; i++) begin
            step(i < 20, 8'(8'h40 + i), i >= 3, 0);
            checks++; if (rd_valid !== exp_rd) begin errors++; $display("FAIL wrap_valid got %0b exp %0b", rd_valid, exp_rd); end
            if (rd_valid === 1'b1 && sb.size() > 0) begin
                exp_d = sb.pop_front();
                checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL wrap_data got %0h exp %0h", rd_data, exp_d); end
            end
        end
        checks++; if (level !== 4'd0 || sb.size() != 0) begin errors++; $display("FAIL wrap_end got %0d exp 0 (sb %0d)", level, sb.size()); end
    endtask

    task automatic test_fwft();
        f_wr_en = 1; f_wr_data = 8'h5A;
        @(posedge clk); #1 f_wr_en = 0;
        checks++; if (f_rd_data !== 8'h5A || f_rd_valid !== 1'b1) begin
            errors++; $display("FAIL fwft_first got %0h v=%0b exp 5a v=1", f_rd_data, f_rd_valid);
        end
        f_wr_en = 1; f_wr_data = 8'h5B;
        @(posedge clk); #1 f_wr_en = 0;
        checks++; if (f_rd_data !== 8'h5A || f_level !== 4'd2) begin
            errors++; $display("FAIL fwft_hold got %0h l=%0d exp 5a l=2", f_rd_data, f_level);
        end
        f_rd_en = 1;
        @(posedge clk); #1 f_rd_en = 0;
        checks++; if (f_rd_data !== 8'h5B || f_rd_valid !== 1'b1) begin
            errors++; $display("FAIL fwft_pop got %0h v=%0b exp 5b v=1", f_rd_data, f_rd_valid);
        end
        f_rd_en = 1;
        @(posedge clk); #1 f_rd_en = 0;
        checks++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0) begin
            errors++; $display("FAIL fwft_empty got e=%0b v=%0b exp e=1 v=0", f_empty, f_rd_valid);
        end
        checks++; if (f_underflow !== 1'b0) begin errors++; $display("FAIL fwft_udf got %0b exp 0", f_underflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL mid_pre got %0d exp 5", level); end
        #2 rst = 1;
        #1;
        checks++; if (level !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_async got l=%0d e=%0b exp l=0 e=1", level, empty); end
        @(posedge clk); #1 rst = 0;
        model_reset();
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 1, 0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin
            errors++; $display("FAIL mid_after got %0h v=%0b exp 77 v=1", rd_data, rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_clr_err();
        test_full_rw();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
